// File: rtl/lsu_mem_master.sv
// Load/store unit front end: turns byte/half/word CPU accesses into word-memory
// transactions, with read-modify-write for sub-word stores and a response timeout.
module lsu_mem_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_request,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0]  SZ_B  = 2'b00;
  localparam logic [1:0]  SZ_H  = 2'b01;
  localparam logic [1:0]  SZ_W  = 2'b10;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, MERGE, WAIT2, RESP} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic                  illegal;

  logic                  req_ready_d, resp_valid_d, resp_err_d, mem_request_d, mem_we_d;
  logic [DATA_WIDTH-1:0] resp_rdata_d, mem_wdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;

  // Little-endian lane extraction with sign or zero extension
  function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0] word,
                                                    input logic [1:0] lo,
                                                    input logic [1:0] size,
                                                    input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (size)
      SZ_B:    return {{24{~uns & b[7]}}, b};
      SZ_H:    return {{16{~uns & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  // Replace the addressed lane(s) of the read word with the store data
  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] word,
                                                  input logic [1:0] lo,
                                                  input logic [1:0] size,
                                                  input logic [DATA_WIDTH-1:0] wd);
    logic [DATA_WIDTH-1:0] m;
    m = word;
    if (size == SZ_B) m[{lo, 3'b000} +: 8] = wd[7:0];
    else              m[{lo[1], 4'b0000} +: 16] = wd[15:0];
    return m;
  endfunction

  assign illegal = (req_size == 2'b11)
                 | ((req_size == SZ_H) & req_addr[0])
                 | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00));

  // Next state, captured request, and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          we_d    = req_we;
          wdata_d = req_wdata;
          data_d  = '0;
          err_d   = illegal;
          state_d = illegal ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT, WAIT2: begin
        if (mem_valid) begin
          if (state_q == WAIT2 || (we_q && size_q == SZ_W)) begin
            state_d = RESP;
          end else if (!we_q) begin
            data_d  = extract(mem_rdata, addr_q[1:0], size_q, uns_q);
            state_d = RESP;
          end else begin
            data_d  = merge(mem_rdata, addr_q[1:0], size_q, wdata_q);
            state_d = MERGE;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MERGE: begin
        cnt_d   = '0;
        state_d = WAIT2;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d   = (state_d == IDLE);
    resp_valid_d  = (state_d == RESP);
    resp_err_d    = (state_d == RESP) & err_d;
    resp_rdata_d  = (state_d == RESP && !err_d && !we_d) ? data_d : '0;
    mem_request_d = (state_d == ISSUE) || (state_d == MERGE);
    mem_we_d      = ((state_d == ISSUE) && we_d && (size_d == SZ_W)) || (state_d == MERGE);
    mem_addr_d    = mem_request_d ? {addr_d[ADDR_WIDTH-1:2], 2'b00} : mem_addr;
    if (state_d == MERGE)                            mem_wdata_d = data_d;
    else if (state_d == ISSUE && we_d && size_d == SZ_W) mem_wdata_d = wdata_d;
    else                                             mem_wdata_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      mem_request <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      err_q       <= err_d;
      req_ready   <= req_ready_d;
      resp_valid  <= resp_valid_d;
      resp_err    <= resp_err_d;
      resp_rdata  <= resp_rdata_d;
      mem_request <= mem_request_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized scoreboard bench for lsu_mem_master against a byte-addressed reference memory.
module tb_lsu_mem_master;

  localparam int unsigned AW = 32;
  localparam int unsigned TO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_request;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_valid = 1'b0;
  logic [31:0]   mem_rdata = '0;

  lsu_mem_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_request(mem_request), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nreq;
    int          acc;
  } exp_t;

  exp_t        sq[$];
  logic [31:0] phys [16];
  logic [7:0]  refmem [64];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          mem_delay = 0;
  bit          mem_drop = 1'b0;
  int          stray_req = 0;
  int          stray_done = 0;
  bit          mon_prev = 1'b0;
  int          mon_rc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input int a, input logic [1:0] sz, input bit uns);
    int     n;
    longint v;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++) v = v | (longint'(refmem[a + i]) << (8 * i));
    if (!uns && n < 4 && v[8 * n - 1]) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input int a, input logic [1:0] sz, input logic [31:0] wd);
    for (int i = 0; i < (1 << sz); i++) refmem[a + i] = wd[8 * i +: 8];
  endtask

  // Word memory: responds one cycle after the request edge plus mem_delay extra cycles
  initial begin
    logic        we;
    logic [AW-1:0] wa;
    logic [31:0] wd;
    forever begin
      @(negedge clk);
      if (stray_req != stray_done) begin
        stray_done++;
        @(posedge clk); #1 mem_valid = 1'b1; mem_rdata = $urandom;
        @(posedge clk); #1 mem_valid = 1'b0;
      end else if (rst_n && mem_request) begin
        we = mem_we; wa = mem_addr; wd = mem_wdata;
        @(posedge clk);
        if (we) phys[wa[5:2]] = wd;
        if (!mem_drop) begin
          repeat (mem_delay) @(posedge clk);
          #1 mem_valid = 1'b1;
          mem_rdata = we ? $urandom : phys[wa[5:2]];
          @(posedge clk); #1 mem_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: per-cycle protocol rules plus scoreboard pop on every response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_rc = 0;
        mon_prev = 1'b0;
      end else begin
        total++;
        if ((mem_request && mon_prev) || (!mem_we && mem_wdata != 0) ||
            (!resp_valid && (resp_err || resp_rdata != 0)) ||
            (mem_request && mem_addr[1:0] != 2'b00)) begin
          bad++;
          $display("FAIL protocol cyc=%0d req=%b prev=%b we=%b wdata=%h rv=%b err=%b rdata=%h addr=%h",
                   cyc, mem_request, mon_prev, mem_we, mem_wdata, resp_valid, resp_err, resp_rdata, mem_addr);
        end
        mon_prev = mem_request;
        if (mem_request) mon_rc++;
        if (resp_valid) begin
          if (sq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_resp at cyc %0d: got resp_valid=1 expected none", cyc);
          end else begin
            e = sq.pop_front();
            chk("resp_err", 64'(resp_err), 64'(e.err));
            chk("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
            chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            chk("mem_requests", 64'(mon_rc), 64'(e.nreq));
          end
          mon_rc = 0;
        end
      end
    end
  end

  task automatic do_req(input bit we, input logic [1:0] sz, input bit uns, input int a,
                        input logic [31:0] wd, input int d, input bit drop, input bit expect_resp);
    exp_t e;
    bit   ill;
    bit   sub;
    int   n;
    ill = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    sub = we && (sz != 2'b10);
    e.err   = ill || drop;
    e.nreq  = ill ? 0 : ((sub && !drop) ? 2 : 1);
    e.lat   = ill ? 1 : (drop ? TO + 2 : (sub ? 5 + 2 * d : 3 + d));
    e.rdata = (e.err || we) ? 32'h0 : ref_load(a, sz, uns);
    if (!e.err && we && expect_resp) ref_store(a, sz, wd);
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL req_ready_wait: got req_ready=0 for 200 cycles expected 1");
      return;
    end
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = AW'(a); req_wdata = wd; mem_delay = d; mem_drop = drop;
    @(posedge clk); #1;
    e.acc = cyc;
    if (expect_resp) sq.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sq.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (sq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending responses expected 0", sq.size());
      sq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          we;
    logic [1:0]  sz;
    int          a;
    for (int i = 0; i < 16; i++) begin
      phys[i] = $urandom;
      for (int b = 0; b < 4; b++) refmem[4 * i + b] = phys[i][8 * b +: 8];
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_mem_request", 64'(mem_request), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    rst_n = 1'b1;

    do_req(1, 2'b10, 0, 16, 32'hDEADBEEF, 0, 0, 1); drain();
    chk("word_store_mem", 64'(phys[4]), 64'hDEADBEEF);
    do_req(0, 2'b10, 0, 16, 32'h0, 0, 0, 1);
    do_req(1, 2'b00, 0, 17, 32'h000000A5, 0, 0, 1); drain();
    chk("byte_store_mem", 64'(phys[4]), 64'hDEADA5EF);
    do_req(0, 2'b00, 0, 17, 32'h0, 0, 0, 1);
    do_req(0, 2'b00, 1, 17, 32'h0, 0, 0, 1);
    do_req(1, 2'b01, 0, 18, 32'h00001234, 0, 0, 1);
    do_req(0, 2'b01, 0, 18, 32'h0, 0, 0, 1); drain();
    chk("half_store_mem", 64'(phys[4]), 64'h1234A5EF);
    do_req(0, 2'b01, 0, 19, 32'h0, 0, 0, 1);
    do_req(0, 2'b11, 0, 16, 32'h0, 0, 0, 1);
    do_req(0, 2'b10, 0, 16, 32'h0, 0, 1, 1);
    do_req(0, 2'b10, 0, 16, 32'h0, 1, 0, 1); drain();

    // Reset during WAIT, then a stray mem_valid pulse
    do_req(0, 2'b10, 0, 20, 32'h0, 0, 1, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    chk("abort_mem_request", 64'(mem_request), 64'd0);
    stray_req++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_resp", 64'(resp_valid), 64'd0);
      chk("abort_idle_ready", 64'(req_ready), 64'd1);
    end
    do_req(0, 2'b10, 1, 16, 32'h0, 0, 0, 1); drain();

    for (int t = 0; t < 300; t++) begin
      we = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = int'($urandom_range(0, 63));
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((1 << sz) - 1);
      do_req(we, sz, 1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 2)),
             !we && ($urandom_range(0, 19) == 0), 1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
